// File: rtl/stage_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// The request fields are held stable from the start of an access until the ack.
interface stage_mem_if #(
  parameter int unsigned DW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// Pipeline MEM stage: issues word-aligned loads/stores, stalls upstream until
// the memory acks, and registers the instruction into the WB slot.
module stage_mem #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  me_valid,
  input  logic [DW-1:0]         me_alu_o,
  input  logic [DW-1:0]         me_regs_data1,
  input  logic [DW-1:0]         me_regs_data2,
  input  logic                  me_mem_read,
  input  logic                  me_mem_write,
  input  logic                  me_mem2reg,
  input  logic                  me_mem_reg2matrix,
  input  logic [1:0]            me_mem_matrix2reg,
  input  logic [1:0]            me_matrix_index,
  input  logic [LANES*DW-1:0]   me_matrix_mul_o,
  input  logic                  flush,

  stage_mem_if.master           dmem,

  output logic                  mem_stall,

  output logic                  wb_valid,
  output logic                  wb_misalign,
  output logic [DW-1:0]         wb_mem_data,
  output logic [DW-1:0]         wb_alu_o,
  output logic [DW-1:0]         wb_regs_data1,
  output logic                  wb_mem2reg,
  output logic                  wb_mem_reg2matrix,
  output logic [1:0]            wb_mem_matrix2reg,
  output logic [1:0]            wb_matrix_index,
  output logic [LANES*DW-1:0]   wb_matrix_mul_o
);

  localparam int unsigned MW = LANES * DW;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  logic   flush_pend;
  logic   mem_access;
  logic   memop;
  logic   misalign;

  assign mem_access = me_valid & (me_mem_read | me_mem_write);
  assign memop      = mem_access & (me_alu_o[1:0] == 2'b00);
  assign misalign   = mem_access & (me_alu_o[1:0] != 2'b00);

  // Hold upstream while an access is being launched or is still outstanding.
  assign mem_stall = ((state == IDLE)   & memop & ~flush) |
                     ((state == ACCESS) & ~dmem.dmem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      flush_pend        <= 1'b0;
      dmem.dmem_req     <= 1'b0;
      dmem.dmem_we      <= 1'b0;
      dmem.dmem_addr    <= '0;
      dmem.dmem_wdata   <= '0;
      wb_valid          <= 1'b0;
      wb_misalign       <= 1'b0;
      wb_mem_data       <= '0;
      wb_alu_o          <= '0;
      wb_regs_data1     <= '0;
      wb_mem2reg        <= 1'b0;
      wb_mem_reg2matrix <= 1'b0;
      wb_mem_matrix2reg <= 2'b00;
      wb_matrix_index   <= 2'b00;
      wb_matrix_mul_o   <= MW'(0);
    end else begin
      case (state)
        IDLE: begin
          // Latch the request so the bus stays stable for the whole access.
          if (memop && !flush) begin
            state           <= ACCESS;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= me_mem_write;
            dmem.dmem_addr  <= {me_alu_o[DW-1:2], 2'b00};
            dmem.dmem_wdata <= me_regs_data2;
          end
        end
        ACCESS: begin
          // A flush cannot abort the bus cycle; remember it and kill on ack.
          if (dmem.dmem_ack) begin
            state         <= IDLE;
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            flush_pend    <= 1'b0;
            if (!dmem.dmem_we) begin
              wb_mem_data <= dmem.dmem_rdata;
            end
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase

      if (!mem_stall) begin
        wb_valid          <= me_valid & ~flush & ~flush_pend;
        wb_misalign       <= misalign & ~flush;
        wb_alu_o          <= me_alu_o;
        wb_regs_data1     <= me_regs_data1;
        wb_mem2reg        <= me_mem2reg;
        wb_mem_reg2matrix <= me_mem_reg2matrix;
        wb_mem_matrix2reg <= me_mem_matrix2reg;
        wb_matrix_index   <= me_matrix_index;
        wb_matrix_mul_o   <= me_matrix_mul_o;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
